// File: rtl/mini_src_pkg.sv
// rtl/mini_src_pkg.sv - shared RAM geometry and arbiter state encoding
package mini_src_pkg;

  localparam int RAM_ADDR_W = 9;
  localparam int RAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational grant picker for the two RAM requesters
// RAM_ARB_ROUND_ROBIN_EN selects round robin on ties; otherwise A beats B.
module ram_arb_pick (
  input  logic a_req,
  input  logic b_req,
  input  logic last_b,
  output logic grant_b
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // On a tie the port that did not win last time gets the grant.
  assign grant_b = b_req & (~a_req | ~last_b);
`else
  logic unused_last_b;
  assign unused_last_b = last_b;
  assign grant_b       = b_req & ~a_req;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - serialises CPU (A) and loader (B) accesses to a 512x32 sync-read RAM
// RAM_ARB_ROUND_ROBIN_EN adds the round-robin pointer; default build is strict A priority.
module ram_arbiter
  import mini_src_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              busy,
  output logic              grant_b,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  arb_state_t state, state_next;

  logic              any_req;
  logic              pick_b;
  logic              last_b;
  logic              op_read;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign any_req = a_req | b_req;

  ram_arb_pick u_pick (
    .a_req   (a_req),
    .b_req   (b_req),
    .last_b  (last_b),
    .grant_b (pick_b)
  );

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Cleared to B so that A takes the first tie after reset.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      last_b <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_b <= pick_b;
    end
  end
`else
  assign last_b = 1'b1;
`endif

  assign sel_we    = pick_b ? b_we    : a_we;
  assign sel_addr  = pick_b ? b_addr  : a_addr;
  assign sel_wdata = pick_b ? b_wdata : a_wdata;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every output is a register; the strobes live only between grant and the RAM capture edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      busy        <= 1'b0;
      grant_b     <= 1'b0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      op_read     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_b     <= pick_b;
            busy        <= 1'b1;
            op_read     <= ~sel_we;
            ram_read    <= ~sel_we;
            ram_write   <= sel_we;
            ram_address <= sel_addr;
            ram_data_in <= sel_wdata;
          end
        end
        ISSUE: begin
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
        end
        WAIT: begin
          if (grant_b) begin
            b_done <= 1'b1;
            if (op_read) b_rdata <= ram_data_out;
          end else begin
            a_done <= 1'b1;
            if (op_read) a_rdata <= ram_data_out;
          end
        end
        DONE: begin
          a_done <= 1'b0;
          b_done <= 1'b0;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a behavioural sync-read RAM
module tb_ram_arbiter;

  logic        clock;
  logic        clear;
  logic        a_req, a_we, a_done;
  logic [8:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_req, b_we, b_done;
  logic [8:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic        busy, grant_b, ram_read, ram_write;
  logic [8:0]  ram_address;
  logic [31:0] ram_data_in, ram_data_out;

  typedef struct packed {
    bit          port;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rd_cycles = 0;
  int   wr_cycles = 0;
  int   a_done_cnt = 0;
  int   b_done_cnt = 0;
  logic [31:0] mem [0:511];

  ram_arbiter dut (
    .clock        (clock),
    .clear        (clear),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_done       (a_done),
    .a_rdata      (a_rdata),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_done       (b_done),
    .b_rdata      (b_rdata),
    .busy         (busy),
    .grant_b      (grant_b),
    .ram_read     (ram_read),
    .ram_write    (ram_write),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[9'h000] = 32'h01000095;
    mem[9'h095] = 32'h000000FF;
    mem[9'h0B0] = 32'h11111111;
    mem[9'h0B1] = 32'h22222222;
    ram_data_out = 32'h0;
    forever begin
      @(posedge clock);
      if (ram_write) mem[ram_address] <= ram_data_in;
      if (ram_read) ram_data_out <= mem[ram_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outputs_or();
    return {31'b0, |{a_done, b_done, a_rdata, b_rdata, busy, grant_b,
                     ram_read, ram_write, ram_address, ram_data_in}};
  endfunction

  always @(negedge clock) begin : monitor
    exp_t e;
    if (ram_read) rd_cycles++;
    if (ram_write) wr_cycles++;
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
    if (a_done || b_done) begin
      check("done_overlap", {31'b0, a_done & b_done}, 32'h0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done a_done=%0b b_done=%0b expected none", a_done, b_done);
      end else begin
        e = sb.pop_front();
        check("done_port", {31'b0, b_done}, {31'b0, e.port});
        check("grant_b", {31'b0, grant_b}, {31'b0, e.port});
        if (e.port) check("b_rdata", b_rdata, e.rdata);
        else        check("a_rdata", a_rdata, e.rdata);
      end
    end
  end

  task automatic push(input bit p, input logic [31:0] d);
    exp_t e;
    e.port  = p;
    e.rdata = d;
    sb.push_back(e);
  endtask

  task automatic access(input bit p, input bit we, input logic [8:0] addr,
                        input logic [31:0] wd, input bit chk_lat);
    int start;
    bit seen;
    @(posedge clock);
    #1;
    if (p) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    start = cyc;
    seen  = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (p ? b_done : a_done) seen = 1'b1;
    end
    if (p) b_req = 1'b0;
    else   a_req = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout port=%0d actual=no_done expected=done", p);
    end else if (chk_lat) begin
      check("latency", cyc - start, 32'd3);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clock);
    check("sb_empty", sb.size(), 32'd0);
  endtask

  task automatic pulse_clear();
    #1;
    clear = 1'b1;
    #1;
    check("clear_outputs", outputs_or(), 32'h0);
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    clear = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", outputs_or(), 32'h0);
    @(posedge clock);
    #1;
    clear = 1'b0;

    // A reads 0x000
    rd_cycles = 0;
    b_done_cnt = 0;
    push(1'b0, 32'h01000095);
    access(1'b0, 1'b0, 9'h000, 32'h0, 1'b1);
    drain();
    check("read_strobe_cycles", rd_cycles, 32'd1);
    check("b_done_idle", b_done_cnt, 32'd0);

    // B writes 0x0A5, A reads it back
    wr_cycles = 0;
    push(1'b1, 32'h0);
    access(1'b1, 1'b1, 9'h0A5, 32'hDEADBEEF, 1'b1);
    push(1'b0, 32'hDEADBEEF);
    access(1'b0, 1'b0, 9'h0A5, 32'h0, 1'b1);
    drain();
    check("write_strobe_cycles", wr_cycles, 32'd1);
    check("b_rdata_kept", b_rdata, 32'h0);

    // Simultaneous single requests: A first, then B
    push(1'b0, 32'h01000095);
    push(1'b1, 32'h000000FF);
    fork
      access(1'b0, 1'b0, 9'h000, 32'h0, 1'b0);
      access(1'b1, 1'b0, 9'h095, 32'h0, 1'b0);
    join
    drain();

    // Two accesses per port, each port re-requesting after its done
`ifdef RAM_ARB_ROUND_ROBIN_EN
    push(1'b0, 32'h01000095);
    push(1'b1, 32'h000000FF);
    push(1'b0, 32'hDEADBEEF);
    push(1'b1, 32'h01000095);
`else
    push(1'b0, 32'h01000095);
    push(1'b0, 32'hDEADBEEF);
    push(1'b1, 32'h000000FF);
    push(1'b1, 32'h01000095);
`endif
    fork
      begin
        access(1'b0, 1'b0, 9'h000, 32'h0, 1'b0);
        access(1'b0, 1'b0, 9'h0A5, 32'h0, 1'b0);
      end
      begin
        access(1'b1, 1'b0, 9'h095, 32'h0, 1'b0);
        access(1'b1, 1'b0, 9'h000, 32'h0, 1'b0);
      end
    join
    drain();

    // clear during WAIT of an A read
    a_done_cnt = 0;
    @(posedge clock);
    #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 9'h095;
    @(posedge clock);
    @(posedge clock);
    pulse_clear();
    repeat (4) @(posedge clock);
    check("aborted_no_done", a_done_cnt, 32'd0);
    push(1'b0, 32'h000000FF);
    access(1'b0, 1'b0, 9'h095, 32'h0, 1'b1);
    drain();

    // clear during ISSUE of a B write: not captured
    b_done_cnt = 0;
    @(posedge clock);
    #1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 9'h0B0; b_wdata = 32'h12345678;
    @(posedge clock);
    #1;
    check("issue_write_strobe", {31'b0, ram_write}, 32'h1);
    pulse_clear();
    push(1'b1, 32'h11111111);
    access(1'b1, 1'b0, 9'h0B0, 32'h0, 1'b1);
    drain();

    // clear during WAIT of a B write: already captured
    @(posedge clock);
    #1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 9'h0B1; b_wdata = 32'hCAFEF00D;
    @(posedge clock);
    @(posedge clock);
    pulse_clear();
    push(1'b1, 32'hCAFEF00D);
    access(1'b1, 1'b0, 9'h0B1, 32'h0, 1'b1);
    drain();
    check("b_aborted_dones", b_done_cnt, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester controller sharing the single-port, synchronous-read 512x32 RAM.
- Port A is the CPU memory interface (MAR/MDR path); port B is the IO/loader port, which preloads programs and inspects memory.
- Owns the RAM read/write/address/data_in pins, serialises one access at a time with a req/done handshake, and returns registered read data.

Parameters:
ADDR_W, 9, RAM address width (512 words)
DATA_W, 32, RAM word width

Ports:
clock  in  1  system clock, all state updates on posedge
clear  in  1  reset, asynchronous, active-high
a_req  in  1  port A request; held high until a_done
a_we  in  1  port A 1=write, 0=read; sampled at grant
a_addr  in  ADDR_W  port A word address; sampled at grant
a_wdata  in  DATA_W  port A write data; sampled at grant
a_done  out  1  one-cycle pulse: port A access complete
a_rdata  out  DATA_W  port A read data, valid while a_done=1 and held afterwards
b_req, b_we, b_addr, b_wdata, b_done, b_rdata  as port A, for port B
busy  out  1  high in any state other than IDLE
grant_b  out  1  owner of the current or last access (0=A, 1=B)
ram_read  out  1  RAM read strobe
ram_write  out  1  RAM write strobe
ram_address  out  ADDR_W  RAM address
ram_data_in  out  DATA_W  RAM write data
ram_data_out  in  DATA_W  RAM registered read data

Behaviour:
- Reset: state=IDLE. All outputs 0: a_done, b_done, a_rdata, b_rdata, busy, grant_b, ram_read, ram_write, ram_address, ram_data_in. The round-robin pointer is cleared to 1 (last=B).
- All outputs are registered. No combinational path exists from inputs to outputs.
- FSM states and transitions:
  - IDLE -> ISSUE when a_req|b_req, arbitrated at edge N.
    - Winner's we/addr/wdata are latched into ram_write/ram_read(=~we)/ram_address/ram_data_in.
    - grant_b is set to the winner; busy=1.
  - ISSUE -> WAIT at edge N+1: the RAM captures the access on this edge. ram_read and ram_write are cleared; address is held.
  - WAIT -> DONE at edge N+2:
    - The winner's done is set.
    - On a read, the winner's rdata <= ram_data_out.
    - On a write, rdata is unchanged.
  - DONE -> IDLE at edge N+3: done cleared, busy cleared.
- Latency and throughput:
  - req seen at edge N gives a done pulse in the cycle after edge N+2.
  - At most one access per 4 cycles.
- Requester handshake:
  - Must drop req in the cycle after done is seen.
  - IDLE samples the dropped req, so there is no double grant.
  - addr/we/wdata may change freely after grant.
- Arbitration: fixed priority, A beats B when both request. Round robin applies only with the macro below.
- A request arriving while busy is not lost: it is serviced from IDLE once its req is still high.
- The loser's done stays 0 and its rdata is untouched.
- Write followed by read of the same address returns the new data, because the accesses are separate RAM edges.
- ram_write is high for exactly one clock per write access, and never in WAIT, DONE or IDLE.
- clear mid-operation:
  - Immediate return to IDLE with all outputs 0.
  - A write already captured at edge N+1 stands; a write not yet captured is never issued.
  - No done pulse is emitted for an aborted access.

Optional Feature:
- RAM_ARB_ROUND_ROBIN_EN defined:
  - On simultaneous a_req and b_req, the port not granted last wins.
  - The pointer updates at each grant; after reset, A wins the first tie.
  - A single requester is always granted.
- Not defined: strict A-over-B priority; the pointer register is not instantiated.

Decomposition:
- Shared package (mini_src_pkg):
  - RAM_ADDR_W=9 and RAM_DATA_W=32.
  - arb_state_t enum {IDLE, ISSUE, WAIT, DONE}, 2-bit encoding.
- Sub-module ram_arb_pick: a small combinational grant picker taking a_req, b_req and last_b, returning grant_b. It isolates the macro-dependent logic.
- FSM and datapath registers stay in ram_arbiter.

Test Plan:
- Reset, then A reads addr 0x000 (RAM holds 32'h01000095):
  - ram_read=1 for one cycle, then a_done pulses 3 edges later.
  - a_rdata=32'h01000095; b_done stays 0.
- B writes 0x0A5 <- 32'hDEADBEEF, then A reads 0x0A5:
  - ram_write is high for exactly one cycle.
  - a_rdata=32'hDEADBEEF; b_rdata unchanged.
- a_req and b_req rise at the same edge with no macro:
  - A is served first (grant_b=0), B is served next (grant_b=1).
  - a_done and b_done never overlap.
- Macro defined, both ports requesting continuously for 4 accesses (each re-asserting after its done):
  - Grant order A,B,A,B.
- clear asserted during WAIT of an A read:
  - All outputs 0 immediately; no a_done pulse.
  - The next A read of 0x095 returns 32'h000000FF normally.
- clear asserted during ISSUE of a B write:
  - Write to the target address is suppressed only if clear precedes edge N+1; a readback checks the old or new value accordingly.
